prog_loader: RTL

- Writer side of the program (instruction) memory: takes a byte stream over a valid/ready handshake and packs it big-endian into BITS_DATA-bit words.
- Writes each word to consecutive memory addresses starting at 0.
- Holds the CPU in reset (cpu_hold) while loading. Sits between the host byte link (UART RX or test bench) and the write port of the program RAM that replaces the preloaded image.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader_byte_packer.sv | 42 ++++
 rtl/prog_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the program-memory loader.
package prog_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic int bytes_per_word(input int bits_data);
      return bits_data / BYTE_W;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte link plus program-RAM write port, seen from the loader (slave) and the host/RAM side (master).
interface prog_loader_if #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 5
);
   logic [7:0]           byte_in;
   logic                 byte_valid;
   logic                 byte_last;
   logic                 byte_ready;
   logic                 we;
   logic [BITS_ADDR-1:0] waddr;
   logic [BITS_DATA-1:0] wdata;

   modport master (
      output byte_in, byte_valid, byte_last,
      input  byte_ready, we, waddr, wdata
   );

   modport slave (
      input  byte_in, byte_valid, byte_last,
      output byte_ready, we, waddr, wdata
   );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Big-endian byte packer: each loaded byte fills the next slot down from the MSB;
// a clear empties the word, so bytes never loaded read back as zero.
module byte_packer
   import prog_loader_pkg::*;
#(
   parameter int BITS_DATA = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clear,
   input  logic                 i_load,
   input  logic [BYTE_W-1:0]    i_byte,
   output logic                 o_last_slot,
   output logic [BITS_DATA-1:0] o_word
);

   localparam int BYTES = bytes_per_word(BITS_DATA);
   localparam int PTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [PTR_W-1:0]     r_ptr;
   logic [BITS_DATA-1:0] r_word;

   // NOTE: reset is synchronous, so it is just the highest-priority branch of the
   // clocked block; all state uses <= so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_ptr  <= '0;
         r_word <= '0;
      end else if (i_load) begin
         for (int k = 0; k < BYTES; k++) begin
            if (r_ptr == PTR_W'(k)) begin
               r_word[BITS_DATA-1-BYTE_W*k -: BYTE_W] <= i_byte;
            end
         end
         r_ptr <= r_ptr + 1'b1;
      end
   end

   assign o_last_slot = (r_ptr == PTR_W'(BYTES - 1));
   assign o_word      = r_word;

endmodule

// File: rtl/prog_loader.sv
// Program-memory loader: packs a byte stream into words written from address 0 upward,
// holding the CPU in reset meanwhile. Define PROG_LOADER_CHECKSUM_EN for a mod-256 byte checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   prog_loader_if.slave       bus,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic [BITS_ADDR:0] word_count
`ifdef PROG_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]         checksum
`endif
);

   localparam logic [BITS_ADDR-1:0] ADDR_MAX = '1;

   state_e               r_state;
   logic [BITS_ADDR-1:0] r_addr;
   logic                 r_byte_ready;
   logic                 r_we;
   logic                 r_last_seen;
   logic                 r_cpu_hold;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_overflow;
   logic [BITS_ADDR:0]   r_word_count;

   logic                 w_accept;
   logic                 w_start_session;
   logic                 w_last_slot;
   logic                 w_word_end;
   logic                 w_clear;
   logic [BITS_DATA-1:0] w_word;

   // byte_ready is only ever high in LOAD, so this also gates acceptance by state.
   assign w_accept        = bus.byte_valid && r_byte_ready;
   assign w_start_session = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_word_end      = w_accept && (bus.byte_last || w_last_slot);
   assign w_clear         = w_start_session || (r_state == WRITE);

   byte_packer #(
      .BITS_DATA (BITS_DATA)
   ) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_clear),
      .i_load      (w_accept),
      .i_byte      (bus.byte_in),
      .o_last_slot (w_last_slot),
      .o_word      (w_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_byte_ready <= 1'b0;
         r_we         <= 1'b0;
         r_last_seen  <= 1'b0;
         r_cpu_hold   <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
         r_word_count <= '0;
      end else if (w_start_session) begin
         r_state      <= LOAD;
         r_addr       <= '0;
         r_byte_ready <= 1'b1;
         r_last_seen  <= 1'b0;
         r_cpu_hold   <= 1'b1;
         r_busy       <= 1'b1;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
         r_word_count <= '0;
      end else begin
         unique case (r_state)
            LOAD: begin
               if (w_word_end) begin
                  r_state      <= WRITE;
                  r_byte_ready <= 1'b0;
                  r_we         <= 1'b1;
                  r_last_seen  <= bus.byte_last;
               end
            end
            WRITE: begin
               r_we         <= 1'b0;
               r_word_count <= r_word_count + 1'b1;
               // The top address ends the session rather than wrapping onto word 0.
               if (r_last_seen || (r_addr == ADDR_MAX)) begin
                  r_state    <= DONE;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_cpu_hold <= 1'b0;
                  r_overflow <= !r_last_seen;
               end else begin
                  r_addr       <= r_addr + 1'b1;
                  r_state      <= LOAD;
                  r_byte_ready <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] r_checksum;

   always_ff @(posedge clk) begin
      if (!rst_n || w_start_session) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= r_checksum + bus.byte_in;
      end
   end

   assign checksum = r_checksum;
`endif

   assign bus.byte_ready = r_byte_ready;
   assign bus.we         = r_we;
   assign bus.waddr      = r_addr;
   assign bus.wdata      = w_word;
   assign cpu_hold       = r_cpu_hold;
   assign busy           = r_busy;
   assign done           = r_done;
   assign overflow       = r_overflow;
   assign word_count     = r_word_count;

endmodule
